// File: rtl/btb_update_queue.sv
// Commit-side training-update queue: buffers retired branch/JAL records and
// presents them one per cycle to the BTB/perceptron update port. Also tracks
// committed global history and mispredict statistics.
module btb_update_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned HIST_BITS = 7,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic                 commit_is_br,
  input  logic                 commit_is_jal,
  input  logic [31:0]          commit_pc,
  input  logic [31:0]          commit_target,
  input  logic                 commit_taken,
  input  logic                 commit_pred,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [31:0]          upd_pc,
  output logic [31:0]          upd_target,
  output logic                 upd_is_br,
  output logic                 upd_is_jal,
  output logic                 upd_taken,
  output logic [HIST_BITS-1:0] hist_out,
  output logic [CNT_BITS-1:0]  br_cnt,
  output logic [CNT_BITS-1:0]  mispred_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        is_br;
    logic        is_jal;
    logic        taken;
  } upd_entry_t;

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic       push_c;
  logic       pop_c;
  logic       mispred_c;
  upd_entry_t wr_entry_c;

  // Handshake flags come straight from the registered occupancy.
  assign commit_ready = (count != CNT_W'(DEPTH));
  assign upd_valid    = (count != CNT_W'(0));

  // Head entry drives the update port directly from storage.
  assign upd_pc     = mem[rd_ptr].pc;
  assign upd_target = mem[rd_ptr].target;
  assign upd_is_br  = mem[rd_ptr].is_br;
  assign upd_is_jal = mem[rd_ptr].is_jal;
  assign upd_taken  = mem[rd_ptr].taken;

  // Push/pop qualification and the record to store; JAL wins when both flags set.
  always_comb begin
    push_c            = commit_valid & commit_ready & (commit_is_br | commit_is_jal);
    pop_c             = upd_valid & upd_ready;
    wr_entry_c.pc     = commit_pc;
    wr_entry_c.target = commit_target;
    wr_entry_c.is_br  = commit_is_br & ~commit_is_jal;
    wr_entry_c.is_jal = commit_is_jal;
    wr_entry_c.taken  = commit_taken;
    mispred_c         = commit_is_jal ? ~commit_pred : (commit_taken ^ commit_pred);
  end

  // FIFO storage write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= wr_entry_c;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Committed global history shifts only on conditional-branch pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_out <= '0;
    end else if (push_c && commit_is_br && !commit_is_jal) begin
      hist_out <= {hist_out[HIST_BITS-2:0], commit_taken};
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (push_c) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_BITS'(1);
      if (mispred_c && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue: directed scenarios plus a random
// phase, all checked against a queue-based reference model.
module tb_btb_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, commit_ready, commit_is_br, commit_is_jal;
  logic [31:0] commit_pc, commit_target;
  logic        commit_taken, commit_pred;
  logic        upd_valid, upd_ready;
  logic [31:0] upd_pc, upd_target;
  logic        upd_is_br, upd_is_jal, upd_taken;
  logic [6:0]  hist_out;
  logic [31:0] br_cnt, mispred_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        br;
    logic        jal;
    logic        taken;
  } rec_t;

  // Reference model state
  rec_t        mq[$];
  logic [6:0]  m_hist;
  longint      m_br;
  longint      m_mis;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  btb_update_queue dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_is_br(commit_is_br), .commit_is_jal(commit_is_jal),
    .commit_pc(commit_pc), .commit_target(commit_target),
    .commit_taken(commit_taken), .commit_pred(commit_pred),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_is_br(upd_is_br), .upd_is_jal(upd_is_jal), .upd_taken(upd_taken),
    .hist_out(hist_out), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_hist = '0;
    m_br   = 0;
    m_mis  = 0;
  endtask

  // Compare every output against the model; head data only when non-empty.
  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(upd_valid), 32'(mq.size() != 0));
    chk({tag, "_ready"}, 32'(commit_ready), 32'(mq.size() < 8));
    chk({tag, "_hist"}, 32'(hist_out), 32'(m_hist));
    chk({tag, "_brcnt"}, br_cnt, 32'(m_br));
    chk({tag, "_miscnt"}, mispred_cnt, 32'(m_mis));
    if (mq.size() != 0) begin
      chk({tag, "_pc"}, upd_pc, mq[0].pc);
      chk({tag, "_tgt"}, upd_target, mq[0].target);
      chk({tag, "_isbr"}, 32'(upd_is_br), 32'(mq[0].br));
      chk({tag, "_isjal"}, 32'(upd_is_jal), 32'(mq[0].jal));
      chk({tag, "_taken"}, 32'(upd_taken), 32'(mq[0].taken));
    end
  endtask

  // Advance one clock: update the model from the current inputs, then check.
  task automatic step(input string tag);
    bit   push, pop;
    rec_t r;
    push = commit_valid && (mq.size() < 8) && (commit_is_br || commit_is_jal);
    pop  = (mq.size() != 0) && upd_ready;
    if (pop) void'(mq.pop_front());
    if (push) begin
      r.pc = commit_pc; r.target = commit_target;
      r.jal = commit_is_jal; r.br = commit_is_br && !commit_is_jal;
      r.taken = commit_taken;
      mq.push_back(r);
      if (r.br) m_hist = {m_hist[5:0], commit_taken};
      if (m_br < SAT) m_br++;
      if ((commit_is_jal ? !commit_pred : (commit_taken != commit_pred)) && m_mis < SAT) m_mis++;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit br, input bit jal, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit tk, input bit pr, input bit ur);
    commit_valid = v; commit_is_br = br; commit_is_jal = jal;
    commit_pc = pc; commit_target = tgt; commit_taken = tk; commit_pred = pr;
    upd_ready = ur;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // 1. reset then idle, data outputs zero
    step("t1");
    chk("t1_pc_zero", upd_pc, 32'h0);
    chk("t1_tgt_zero", upd_target, 32'h0);
    chk("t1_ready", 32'(commit_ready), 32'd1);

    // 2. single mispredicted taken branch
    drive(1, 1, 0, 32'h100, 32'h140, 1, 0, 0);
    step("t2");
    chk("t2_pc", upd_pc, 32'h100);
    chk("t2_hist", 32'(hist_out), 32'h01);
    chk("t2_brcnt", br_cnt, 32'd1);
    chk("t2_miscnt", mispred_cnt, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step("t2_drain");

    // 3. fill with 8 JALs, reject a 9th, drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 32'(i * 4), 32'h2000 + 32'(i), 0, 1, 0);
      step("t3_fill");
    end
    chk("t3_full_ready", 32'(commit_ready), 32'd0);
    drive(1, 0, 1, 32'h999, 32'h0, 0, 1, 0);
    step("t3_reject");
    for (int i = 0; i < 8; i++) begin
      chk("t3_order_pc", upd_pc, 32'(i * 4));
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step("t3_pop");
    end
    chk("t3_empty", 32'(upd_valid), 32'd0);

    // 4. full queue, simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 32'h400 + 32'(i * 4), 32'h500, i[0], 0, 0);
      step("t4_fill");
    end
    drive(1, 1, 0, 32'hBAD0, 32'h0, 1, 1, 1);
    step("t4_pushpop");
    chk("t4_ready", 32'(commit_ready), 32'd1);
    chk("t4_head", upd_pc, 32'h404);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (7) step("t4_drain");

    // 5. steady stream with ready held high
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 32'h800 + 32'(i * 4), 32'h900, 1, 1, 1);
      step("t5_stream");
      chk("t5_valid", 32'(upd_valid), 32'd1);
      chk("t5_pc", upd_pc, 32'h800 + 32'(i * 4));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step("t5_drain");

    // 6. ALU op dropped
    drive(1, 0, 0, 32'hA0A0, 32'h0, 1, 0, 0);
    step("t6_alu");

    // random phase
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0, $urandom, $urandom,
            $urandom % 2, $urandom % 2, ($urandom % 3) != 0);
      step("rnd");
    end

    // 6b. async reset with three entries queued
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("t6_pre");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'hC00 + 32'(i * 4), 32'hD00, 1, 0, 0);
      step("t6_fill");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(upd_valid), 32'd0);
    chk("t6_async_ready", 32'(commit_ready), 32'd1);
    chk("t6_async_hist", 32'(hist_out), 32'd0);
    chk("t6_async_brcnt", br_cnt, 32'd0);
    chk("t6_async_miscnt", mispred_cnt, 32'd0);
    chk("t6_async_pc", upd_pc, 32'd0);
    model_clear();
    @(posedge clk); #1 rst = 1'b0;
    step("t6_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
